// File: rtl/red_pitaya_dac_ramp_pkg.sv
// Shared types and constants for the DAC output conditioning stage.
// Ramp FSM state encoding and gain scaling helpers.
package red_pitaya_dac_ramp_pkg;

  typedef enum logic [1:0] {
    StOff  = 2'd0,
    StUp   = 2'd1,
    StRun  = 2'd2,
    StDown = 2'd3
  } ramp_state_e;

  localparam int unsigned GwDefault = 16;

  function automatic int unsigned unity(input int unsigned gw);
    return 32'd1 << gw;
  endfunction

endpackage

// File: rtl/red_pitaya_slew_lim.sv
// Output slew-rate limiter: moves dat_o toward tgt_i by at most slew_max_i per cycle.
// A slew_max_i of zero passes the target straight through.
module red_pitaya_slew_lim #(
  parameter int unsigned DAC_DW = 14
) (
  input  logic              dac_clk_i,
  input  logic              dac_rstn_i,
  input  logic [DAC_DW-1:0] tgt_i,
  input  logic [DAC_DW-1:0] slew_max_i,
  output logic [DAC_DW-1:0] dat_o
);

  logic [DAC_DW-1:0] dat_q, dat_d;
  logic [DAC_DW:0]   tgt_ext, dat_ext, slew_ext, diff, abs_diff, stepped;
  logic              bypass;

  always_comb begin
    tgt_ext  = {tgt_i[DAC_DW-1], tgt_i};
    dat_ext  = {dat_q[DAC_DW-1], dat_q};
    slew_ext = {1'b0, slew_max_i};
    diff     = tgt_ext - dat_ext;
    abs_diff = diff[DAC_DW] ? (~diff + 1'b1) : diff;
    bypass   = (slew_max_i == '0) || (abs_diff <= slew_ext);
    // The stepped value lies between dat_q and tgt_i, so it never leaves the sample range.
    stepped  = diff[DAC_DW] ? (dat_ext - slew_ext) : (dat_ext + slew_ext);
    dat_d    = bypass ? tgt_i : DAC_DW'(stepped);
  end

  always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
    if (!dac_rstn_i) begin
      dat_q <= '0;
    end else begin
      dat_q <= dat_d;
    end
  end

  assign dat_o = dat_q;

endmodule

// File: rtl/red_pitaya_dac_ramp.sv
// Per-channel DAC conditioning: soft-start/soft-stop gain ramp on enable changes,
// gain multiply (S1) and slew-rate limit (S2), two cycles from dat_i to dat_o.
module red_pitaya_dac_ramp
  import red_pitaya_dac_ramp_pkg::*;
#(
  parameter int unsigned DAC_DW = 14,
  parameter int unsigned GW     = GwDefault
) (
  input  logic              dac_clk_i,
  input  logic              dac_rstn_i,
  input  logic [DAC_DW-1:0] dat_i,
  input  logic              en_i,
  input  logic [GW-1:0]     gain_step_i,
  input  logic [DAC_DW-1:0] slew_max_i,
  output logic [DAC_DW-1:0] dat_o,
  output logic [1:0]        state_o,
  output logic              busy_o
);

  localparam int unsigned PW    = DAC_DW + GW + 2;
  localparam logic [GW:0] Unity = (GW + 1)'(unity(GW));

  ramp_state_e       state_q;
  logic [GW:0]       gain_q;
  logic              busy_q;
  logic [DAC_DW-1:0] tgt_q, tgt_d;

  logic              step_zero;
  logic [GW+1:0]     gain_sum;
  logic [GW:0]       gain_inc, gain_dec;
  logic [PW-1:0]     dat_ext, gain_ext;
  logic signed [PW-1:0] prod;

  // Saturating gain arithmetic; a zero step means switch straight to the end point.
  always_comb begin
    step_zero = (gain_step_i == '0);
    gain_sum  = {1'b0, gain_q} + {2'b0, gain_step_i};
    if (step_zero || (gain_sum >= {1'b0, Unity})) begin
      gain_inc = Unity;
    end else begin
      gain_inc = gain_sum[GW:0];
    end
    if (step_zero || (gain_q <= {1'b0, gain_step_i})) begin
      gain_dec = '0;
    end else begin
      gain_dec = gain_q - {1'b0, gain_step_i};
    end
  end

  always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
    if (!dac_rstn_i) begin
      state_q <= StOff;
      gain_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StOff: begin
          gain_q <= '0;
          if (en_i) begin
            if (step_zero) begin
              gain_q  <= Unity;
              state_q <= StRun;
              busy_q  <= 1'b0;
            end else begin
              state_q <= StUp;
              busy_q  <= 1'b1;
            end
          end
        end
        StUp: begin
          if (!en_i) begin
            // Reverse from the current gain; no jump.
            state_q <= StDown;
            busy_q  <= 1'b1;
          end else begin
            gain_q <= gain_inc;
            if (gain_inc == Unity) begin
              state_q <= StRun;
              busy_q  <= 1'b0;
            end
          end
        end
        StRun: begin
          gain_q <= Unity;
          if (!en_i) begin
            if (step_zero) begin
              gain_q  <= '0;
              state_q <= StOff;
              busy_q  <= 1'b0;
            end else begin
              state_q <= StDown;
              busy_q  <= 1'b1;
            end
          end
        end
        StDown: begin
          if (en_i) begin
            state_q <= StUp;
            busy_q  <= 1'b1;
          end else begin
            gain_q <= gain_dec;
            if (gain_dec == '0) begin
              state_q <= StOff;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= StOff;
          gain_q  <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // S1: floor(dat_i * gain / UNITY); magnitude never exceeds |dat_i|.
  always_comb begin
    dat_ext  = {{(PW - DAC_DW){dat_i[DAC_DW-1]}}, dat_i};
    gain_ext = {{(PW - GW - 1){1'b0}}, gain_q};
    prod     = $signed(dat_ext * gain_ext);
    tgt_d    = DAC_DW'(prod >>> GW);
  end

  always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
    if (!dac_rstn_i) begin
      tgt_q <= '0;
    end else begin
      tgt_q <= tgt_d;
    end
  end

  red_pitaya_slew_lim #(
    .DAC_DW (DAC_DW)
  ) u_slew_lim (
    .dac_clk_i  (dac_clk_i),
    .dac_rstn_i (dac_rstn_i),
    .tgt_i      (tgt_q),
    .slew_max_i (slew_max_i),
    .dat_o      (dat_o)
  );

  assign state_o = state_q;
  assign busy_o  = busy_q;

endmodule

// File: tb/tb_red_pitaya_dac_ramp.sv
// Self-checking bench for red_pitaya_dac_ramp: cycle reference model feeding an
// expected-value queue, plus directed ramp, abort, slew, immediate and reset scenarios.
module tb_red_pitaya_dac_ramp;

  logic        clk = 1'b0;
  logic        rstn;
  logic [13:0] dat;
  logic        en;
  logic [15:0] step;
  logic [13:0] slew;
  logic [13:0] dat_o;
  logic [1:0]  state;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int dat;
    int st;
    int busy;
  } exp_t;

  exp_t   exp_q[$];
  int     m_state, m_tgt, m_dat;
  longint m_gain;

  always #4 clk = ~clk;

  red_pitaya_dac_ramp dut (
    .dac_clk_i   (clk),
    .dac_rstn_i  (rstn),
    .dat_i       (dat),
    .en_i        (en),
    .gain_step_i (step),
    .slew_max_i  (slew),
    .dat_o       (dat_o),
    .state_o     (state),
    .busy_o      (busy)
  );

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int sx(input logic [13:0] v);
    return int'($signed(v));
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_gain  = 0;
    m_tgt   = 0;
    m_dat   = 0;
    exp_q.delete();
  endtask

  // Reference behaviour for one clock edge, using the inputs currently driven.
  task automatic model_step();
    int     d, nd, nt, ns, s, sl;
    longint ng, p;
    exp_t   e;
    s  = int'(step);
    sl = int'(slew);
    d  = m_tgt - m_dat;
    if (sl == 0 || iabs(d) <= sl) nd = m_tgt;
    else nd = m_dat + ((d > 0) ? sl : -sl);
    p  = longint'(sx(dat)) * m_gain;
    nt = int'(p >>> 16);
    ns = m_state;
    ng = m_gain;
    case (m_state)
      0: begin
        ng = 0;
        if (en) begin
          if (s == 0) begin ng = 65536; ns = 2; end
          else ns = 1;
        end
      end
      1: begin
        if (!en) ns = 3;
        else begin
          ng = (s == 0 || m_gain + s > 65536) ? 65536 : m_gain + s;
          if (ng == 65536) ns = 2;
        end
      end
      2: begin
        ng = 65536;
        if (!en) begin
          if (s == 0) begin ng = 0; ns = 0; end
          else ns = 3;
        end
      end
      default: begin
        if (en) ns = 1;
        else begin
          ng = (s == 0 || m_gain - s < 0) ? 0 : m_gain - s;
          if (ng == 0) ns = 0;
        end
      end
    endcase
    m_state = ns;
    m_gain  = ng;
    m_tgt   = nt;
    m_dat   = nd;
    e.dat   = nd;
    e.st    = ns;
    e.busy  = (ns == 1 || ns == 3) ? 1 : 0;
    exp_q.push_back(e);
  endtask

  // One clock: push the expectation, let the edge pass, compare the DUT against it.
  task automatic tick();
    exp_t e;
    int   prev, sl;
    model_step();
    prev = sx(dat_o);
    sl   = int'(slew);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_eq("dat_o", sx(dat_o), e.dat);
    check_eq("state_o", state, e.st);
    check_eq("busy_o", busy, e.busy);
    if (sl != 0) check_eq("slew_bound", (iabs(sx(dat_o) - prev) <= sl) ? 1 : 0, 1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int up_cnt, peak, changes, prev, busy_seen;

    // Reset held with live inputs.
    rstn = 1'b0;
    dat  = 14'd8000;
    en   = 1'b1;
    step = 16'h1000;
    slew = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_dat_o", sx(dat_o), 0);
    check_eq("rst_state", state, 0);
    check_eq("rst_busy", busy, 0);
    en   = 1'b0;
    rstn = 1'b1;
    repeat (3) tick();

    // Soft start at step UNITY/16.
    en     = 1'b1;
    up_cnt = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (state == 2'd1) up_cnt++;
      if (c >= 4 && c <= 19) check_eq("ramp_up_val", sx(dat_o), 500 * (c - 3));
    end
    check_eq("ramp_up_cycles", up_cnt, 16);
    check_eq("ramp_up_state", state, 2);
    check_eq("ramp_up_final", sx(dat_o), 8000);

    // Abort the ramp at half gain.
    en   = 1'b0;
    step = '0;
    repeat (4) tick();
    en   = 1'b1;
    step = 16'h1000;
    repeat (9) tick();
    en   = 1'b0;
    peak = -100000;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (sx(dat_o) > peak) peak = sx(dat_o);
    end
    check_eq("abort_peak", peak, 4000);
    check_eq("abort_state", state, 0);
    check_eq("abort_dat_o", sx(dat_o), 0);

    // Slew limiting in RUN.
    en   = 1'b1;
    step = '0;
    dat  = '0;
    repeat (4) tick();
    slew    = 14'd100;
    dat     = 14'd8000;
    changes = 0;
    for (int c = 0; c < 90; c++) begin
      prev = sx(dat_o);
      tick();
      if (sx(dat_o) != prev) changes++;
    end
    check_eq("slew_up_cycles", changes, 80);
    check_eq("slew_up_final", sx(dat_o), 8000);
    dat     = 14'h2000;
    changes = 0;
    for (int c = 0; c < 170; c++) begin
      prev = sx(dat_o);
      tick();
      if (sx(dat_o) != prev) changes++;
    end
    check_eq("slew_dn_cycles", changes, 162);
    check_eq("slew_dn_final", sx(dat_o), -8192);

    // Asynchronous reset in the middle of a soft stop.
    slew = '0;
    step = 16'h0100;
    en   = 1'b0;
    repeat (20) tick();
    check_eq("pre_rst_busy", busy, 1);
    #2;
    rstn = 1'b0;
    #1;
    check_eq("async_rst_dat_o", sx(dat_o), 0);
    check_eq("async_rst_state", state, 0);
    check_eq("async_rst_busy", busy, 0);
    model_reset();
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // Immediate switching with zero step.
    dat  = 14'd1234;
    step = '0;
    slew = '0;
    repeat (2) tick();
    en        = 1'b1;
    busy_seen = 0;
    repeat (3) begin
      tick();
      if (busy) busy_seen = 1;
    end
    check_eq("imm_on", sx(dat_o), 1234);
    en = 1'b0;
    repeat (3) begin
      tick();
      if (busy) busy_seen = 1;
    end
    check_eq("imm_off", sx(dat_o), 0);
    check_eq("imm_busy", busy_seen, 0);

    // Randomised traffic against the model.
    for (int c = 0; c < 20000; c++) begin
      dat = 14'($urandom);
      if (c % 4000 < 200) en = ~en;
      else if ($urandom_range(0, 15) == 0) en = ~en;
      if ($urandom_range(0, 31) == 0) begin
        case ($urandom_range(0, 3))
          0:       step = '0;
          1:       step = 16'($urandom_range(1, 255));
          2:       step = 16'($urandom_range(256, 65535));
          default: step = 16'hffff;
        endcase
      end
      if ($urandom_range(0, 63) == 0) begin
        slew = ($urandom_range(0, 2) == 0) ? 14'd0 : 14'($urandom_range(1, 16383));
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
